dashed_net_renderer: RTL and testbench

- Parametrised successor to the single-mode centre-net hit tester.
- Classifies each polled pixel against a vertical net column.
  - Hit: the pixel is in a dash.
  - Hit2: the pixel is in a gap.
- Dash and gap lengths are independent and runtime-configurable. Four display modes are supported. The dash pattern can scroll vertically frame-to-frame.
- Sits between the VGA pixel poller and the colour mux, in parallel with the paddle/ball hit testers.
- Uses a per-line phase counter instead of a modulo operator.

---
 rtl/dashed_net_renderer.sv | 159 +++++++++++++++
 tb/tb_dashed_net_renderer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dashed_net_renderer.sv
// Centre-net hit tester: classifies each polled pixel of a vertical column as a dash (Hit)
// or gap (Hit2) pixel, with frame-latched configuration and per-frame pattern scrolling.
module dashed_net_renderer #(
    parameter int XW       = 11,
    parameter int LW       = 4,
    parameter int DEF_DASH = 4,
    parameter int DEF_GAP  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PollValid,
    input  logic [9:0]    PollX,
    input  logic [8:0]    PollY,
    input  logic [XW-1:0] ObjectX,
    input  logic [LW-1:0] ObjectW,
    input  logic [LW-1:0] DashLen,
    input  logic [LW-1:0] GapLen,
    input  logic [1:0]    Mode,
    input  logic          ScrollEn,
    input  logic          ScrollDir,
    output logic          Hit,
    output logic          Hit2,
    output logic          HitValid
);
    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_SOLID = 2'b01,
        MODE_DASH  = 2'b10,
        MODE_INV   = 2'b11
    } mode_e;

    localparam int            PW  = LW + 1;
    localparam int            CW  = XW + 1;
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [LW-1:0] dash_q, dash_d, gap_q, gap_d;
    mode_e         mode_q, mode_d;
    logic          scroll_en_q, scroll_en_d;
    logic [PW-1:0] scroll_off_q, scroll_off_d, phase_q, phase_d;
    logic          first_q, first_d;
    logic [8:0]    last_y_q, last_y_d;
    logic          v1_q, v1_d, inx1_q, inx1_d;
    logic [PW-1:0] ph1_q, ph1_d;
    logic          hit_q, hit_d, hit2_q, hit2_d, hit_valid_q, hit_valid_d;

    logic          frame_start, new_line, in_dash;
    logic [PW-1:0] period_cur, period_new, off_clamped, off_stepped;
    logic [CW-1:0] px_ext, col_lo, col_hi;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        dash_d       = dash_q;
        gap_d        = gap_q;
        mode_d       = mode_q;
        scroll_en_d  = scroll_en_q;
        scroll_off_d = scroll_off_q;
        phase_d      = phase_q;
        first_d      = first_q;
        last_y_d     = last_y_q;

        frame_start = PollValid && (PollY == '0) && (first_q || (last_y_q != '0));
        new_line    = PollValid && (PollY != last_y_q) && (PollY != '0);
        period_cur  = PW'(dash_q) + PW'(gap_q);
        period_new  = PW'(DashLen) + PW'(GapLen);

        // A shorter new period can strand the old offset out of range; clamp before stepping.
        off_clamped = (scroll_off_q >= period_new) ? '0 : scroll_off_q;
        off_stepped = off_clamped;
        if (ScrollEn) begin
            if (ScrollDir) begin
                off_stepped = (off_clamped + ONE == period_new) ? '0 : off_clamped + ONE;
            end else begin
                off_stepped = (off_clamped == '0) ? period_new - ONE : off_clamped - ONE;
            end
        end
        if (period_new == '0) begin
            off_stepped = '0;
        end

        if (frame_start) begin
            dash_d       = DashLen;
            gap_d        = GapLen;
            mode_d       = mode_e'(Mode);
            scroll_en_d  = ScrollEn;
            scroll_off_d = off_stepped;
            phase_d      = off_stepped;
        end else if (new_line) begin
            phase_d = (phase_q + ONE == period_cur) ? '0 : phase_q + ONE;
        end

        if (PollValid) begin
            last_y_d = PollY;
            first_d  = 1'b0;
        end
    end

    always_comb begin
        px_ext = CW'(PollX);
        col_lo = CW'(ObjectX);
        col_hi = CW'(ObjectX) + CW'(ObjectW);
        v1_d   = PollValid;
        inx1_d = (col_lo <= px_ext) && (px_ext <= col_hi);
        ph1_d  = phase_d;
    end

    always_comb begin
        in_dash     = ph1_q < PW'(dash_q);
        hit_valid_d = v1_q;
        hit_d       = 1'b0;
        hit2_d      = 1'b0;
        if (v1_q && inx1_q) begin
            case (mode_q)
                MODE_OFF:   ;
                MODE_SOLID: hit_d = 1'b1;
                MODE_DASH:  begin hit_d = in_dash;  hit2_d = !in_dash; end
                MODE_INV:   begin hit_d = !in_dash; hit2_d = in_dash;  end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            dash_q       <= LW'(DEF_DASH);
            gap_q        <= LW'(DEF_GAP);
            mode_q       <= MODE_OFF;
            scroll_en_q  <= 1'b0;
            scroll_off_q <= '0;
            phase_q      <= '0;
            first_q      <= 1'b1;
            last_y_q     <= '0;
            v1_q         <= 1'b0;
            inx1_q       <= 1'b0;
            ph1_q        <= '0;
            hit_q        <= 1'b0;
            hit2_q       <= 1'b0;
            hit_valid_q  <= 1'b0;
        end else begin
            dash_q       <= dash_d;
            gap_q        <= gap_d;
            mode_q       <= mode_d;
            scroll_en_q  <= scroll_en_d;
            scroll_off_q <= scroll_off_d;
            phase_q      <= phase_d;
            first_q      <= first_d;
            last_y_q     <= last_y_d;
            v1_q         <= v1_d;
            inx1_q       <= inx1_d;
            ph1_q        <= ph1_d;
            hit_q        <= hit_d;
            hit2_q       <= hit2_d;
            hit_valid_q  <= hit_valid_d;
        end
    end

    assign Hit      = hit_q;
    assign Hit2     = hit2_q;
    assign HitValid = hit_valid_q;
endmodule

// File: tb/tb_dashed_net_renderer.sv
// Bench for dashed_net_renderer: a line-count/modulo model checked every cycle, plus
// directed polls with hand-computed literal results.
module tb_dashed_net_renderer;
    localparam int XW = 11;
    localparam int LW = 4;
    localparam int DEF_DASH = 4;
    localparam int DEF_GAP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          PollValid;
    logic [9:0]    PollX;
    logic [8:0]    PollY;
    logic [XW-1:0] ObjectX;
    logic [LW-1:0] ObjectW;
    logic [LW-1:0] DashLen;
    logic [LW-1:0] GapLen;
    logic [1:0]    Mode;
    logic          ScrollEn;
    logic          ScrollDir;
    logic          Hit, Hit2, HitValid;

    int total = 0;
    int bad = 0;

    int m_dash, m_gap, m_mode, m_sen, m_off, m_first, m_last_y, m_lines;

    always #5 clk = ~clk;

    dashed_net_renderer #(.XW(XW), .LW(LW), .DEF_DASH(DEF_DASH), .DEF_GAP(DEF_GAP)) dut (
        .clk(clk), .reset(reset), .PollValid(PollValid), .PollX(PollX), .PollY(PollY),
        .ObjectX(ObjectX), .ObjectW(ObjectW), .DashLen(DashLen), .GapLen(GapLen),
        .Mode(Mode), .ScrollEn(ScrollEn), .ScrollDir(ScrollDir),
        .Hit(Hit), .Hit2(Hit2), .HitValid(HitValid)
    );

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got {HitValid,Hit,Hit2}=%b, expected %b", name, $time, act, exp);
        end
    endtask

    // Phase of a pixel = (frame scroll offset + lines since frame start) mod period.
    task automatic model_step(output logic [2:0] r);
        int  p, ph, px, lo, hi;
        bit  d, inx;
        r = 3'b000;
        if (reset) begin
            m_dash = DEF_DASH; m_gap = DEF_GAP; m_mode = 0; m_sen = 0;
            m_off = 0; m_first = 1; m_last_y = 0; m_lines = 0;
            return;
        end
        if (!PollValid) return;
        if (int'(PollY) == 0 && (m_first != 0 || m_last_y != 0)) begin
            m_dash = int'(DashLen);
            m_gap  = int'(GapLen);
            m_mode = int'(Mode);
            m_sen  = int'(ScrollEn);
            p = m_dash + m_gap;
            if (m_off >= p) m_off = 0;
            if (m_sen != 0 && p > 0) m_off = ScrollDir ? (m_off + 1) % p : (m_off + p - 1) % p;
            if (p == 0) m_off = 0;
            m_lines = 0;
        end else if (int'(PollY) != m_last_y) begin
            m_lines++;
        end
        m_last_y = int'(PollY);
        m_first = 0;
        p  = m_dash + m_gap;
        ph = (p == 0) ? 0 : (m_off + m_lines) % p;
        d  = ph < m_dash;
        px = int'(PollX);
        lo = int'(ObjectX);
        hi = lo + int'(ObjectW);
        inx = (px >= lo) && (px <= hi);
        r[2] = 1'b1;
        if (inx) begin
            case (m_mode)
                1: r[1] = 1'b1;
                2: begin r[1] = d;  r[0] = !d; end
                3: begin r[1] = !d; r[0] = d;  end
                default: ;
            endcase
        end
    endtask

    // Every-cycle comparison against the model, delayed by the two-cycle latency.
    initial begin
        logic [2:0] s1, s2, now;
        s1 = 3'b000;
        s2 = 3'b000;
        forever begin
            @(posedge clk);
            model_step(now);
            s2 = reset ? 3'b000 : s1;
            s1 = reset ? 3'b000 : now;
            #1;
            check("model", {HitValid, Hit, Hit2}, s2);
        end
    end

    task automatic drive(input logic v, input int x, input int y);
        @(negedge clk);
        PollValid = v;
        PollX = 10'(x);
        PollY = 9'(y);
    endtask

    task automatic expect_last(input string name, input logic h, input logic h2);
        @(negedge clk);
        PollValid = 1'b0;
        @(posedge clk);
        #2;
        check(name, {HitValid, Hit, Hit2}, {1'b1, h, h2});
    endtask

    task automatic scan(input int x, input int y0, input int y1);
        for (int y = y0; y <= y1; y++) drive(1'b1, x, y);
    endtask

    task automatic scan_cols(input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = 315; x <= 319; x++) drive(1'b1, x, y);
    endtask

    initial begin
        reset = 1'b1; PollValid = 1'b0; PollX = '0; PollY = '0;
        ObjectX = 11'd316; ObjectW = 4'd2; DashLen = 4'd4; GapLen = 4'd4;
        Mode = 2'b10; ScrollEn = 1'b0; ScrollDir = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;
        check("reset_state", {HitValid, Hit, Hit2}, 3'b000);

        // Basic 4/4 dashes
        scan(317, 0, 15);
        drive(1'b1, 317, 16); expect_last("y16_dash", 1'b1, 1'b0);

        // Column bounds
        drive(1'b1, 315, 17); expect_last("x315_out", 1'b0, 1'b0);
        drive(1'b1, 319, 18); expect_last("x319_out", 1'b0, 1'b0);
        drive(1'b1, 316, 19); expect_last("x316_left", 1'b1, 1'b0);
        drive(1'b1, 318, 20); expect_last("x318_right", 1'b0, 1'b1);
        ObjectX = 11'd2040; ObjectW = 4'd15;
        drive(1'b1, 1023, 21); expect_last("no_wrap", 1'b0, 1'b0);
        ObjectX = 11'd316; ObjectW = 4'd2;

        // Scrolling up with 3/2
        DashLen = 4'd3; GapLen = 4'd2; ScrollEn = 1'b1; ScrollDir = 1'b1;
        scan(317, 0, 4);
        scan(317, 0, 4);
        drive(1'b1, 317, 0); expect_last("scroll_f3_y0", 1'b0, 1'b1);
        drive(1'b1, 317, 1); expect_last("scroll_f3_y1", 1'b0, 1'b1);
        drive(1'b1, 317, 2); expect_last("scroll_f3_y2", 1'b1, 1'b0);
        scan(317, 3, 4);
        scan(317, 0, 4);
        scan(317, 0, 4);
        ScrollDir = 1'b0;
        drive(1'b1, 317, 0);
        drive(1'b1, 317, 1); expect_last("scroll_down_wrap", 1'b1, 1'b0);
        scan(317, 2, 4);

        // Mid-frame config change takes effect next frame
        ScrollEn = 1'b0; DashLen = 4'd4; GapLen = 4'd4;
        scan(317, 0, 99);
        DashLen = 4'd2;
        scan(317, 100, 101);
        drive(1'b1, 317, 102); expect_last("no_tear", 1'b1, 1'b0);
        scan(317, 103, 105);
        scan(317, 0, 1);
        drive(1'b1, 317, 2); expect_last("next_frame_2_4", 1'b1, 1'b0);
        ScrollEn = 1'b1; ScrollDir = 1'b1;
        scan(317, 0, 3);
        GapLen = 4'd1;
        drive(1'b1, 317, 0);
        drive(1'b1, 317, 1); expect_last("clamp_then_step", 1'b0, 1'b1);

        // Display modes and degenerate lengths
        ScrollEn = 1'b0; DashLen = 4'd4; GapLen = 4'd4; Mode = 2'b00;
        scan_cols(0, 3);
        drive(1'b1, 317, 4); expect_last("mode_off", 1'b0, 1'b0);
        Mode = 2'b01;
        scan_cols(0, 3);
        drive(1'b1, 316, 4); expect_last("mode_solid", 1'b1, 1'b0);
        Mode = 2'b11;
        drive(1'b1, 317, 0); expect_last("mode_inverted", 1'b0, 1'b1);
        scan_cols(1, 7);
        Mode = 2'b10; DashLen = 4'd0; GapLen = 4'd5;
        scan_cols(0, 6);
        drive(1'b1, 317, 7); expect_last("dash_zero", 1'b0, 1'b1);
        DashLen = 4'd3; GapLen = 4'd0;
        scan_cols(0, 4);
        drive(1'b1, 317, 5); expect_last("gap_zero", 1'b1, 1'b0);
        DashLen = 4'd0; GapLen = 4'd0;
        scan(317, 0, 5);
        drive(1'b1, 317, 6); expect_last("period_zero", 1'b0, 1'b1);

        // Idle cycles mid-line, then reset mid-frame
        DashLen = 4'd4; GapLen = 4'd4;
        scan(317, 0, 5);
        drive(1'b1, 316, 6);
        repeat (3) drive(1'b0, 316, 6);
        drive(1'b1, 318, 6);
        drive(1'b1, 317, 7); expect_last("idle_resume", 1'b0, 1'b1);
        scan(317, 8, 199);
        drive(1'b1, 317, 200);
        reset = 1'b1;
        drive(1'b1, 317, 201);
        reset = 1'b0;
        expect_last("post_reset_off", 1'b0, 1'b0);
        scan(317, 0, 3);
        drive(1'b1, 317, 4); expect_last("def_restart", 1'b0, 1'b1);

        repeat (4) drive(1'b0, 0, 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
